// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter that turns four pod read bursts into DDR address beats
// and routes the fixed-latency read data back to the requesting pod.
module ddr_read_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned OFFCHIP_DW = 512,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned RD_LAT     = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_valid,
  input  logic [4*ADDR_W-1:0]     req_addr,
  input  logic [4*LEN_W-1:0]      req_len,
  output logic [3:0]              req_ready,
  output logic [ADDR_W-1:0]       ddr_raddr,
  output logic                    ddr_raddr_valid,
  input  logic [OFFCHIP_DW-1:0]   ddr_rdata,
  output logic [3:0]              rsp_valid,
  output logic [3:0]              rsp_last,
  output logic [OFFCHIP_DW-1:0]   rsp_data,
  output logic                    busy
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic [1:0]          pod_q, pod_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  logic [RD_LAT-1:0]   pvld_q, pvld_d;
  logic [RD_LAT-1:0]   plast_q, plast_d;
  logic [1:0]          pid_q [RD_LAT];
  logic [1:0]          pid_d [RD_LAT];

  logic                grant_vld;
  logic [1:0]          grant_idx;
  logic                issue_c;
  logic                issue_last_c;

  // Round-robin search starting one past the last granted pod
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      logic [1:0] cand;
      cand = 2'(last_grant_q + 2'(i));
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state and request-accept logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pod_d        = pod_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    req_ready    = 4'b0000;
    issue_c      = 1'b0;
    issue_last_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld && !rst) begin
          req_ready[grant_idx] = 1'b1;
          last_grant_d = grant_idx;
          pod_d        = grant_idx;
          addr_d       = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
          len_d        = req_len[32'(grant_idx)*LEN_W +: LEN_W];
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        issue_c      = !rst;
        issue_last_c = (cnt_q == len_q);
        // Counter stops at len so a full-range length never overflows
        if (cnt_q == len_q) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q + LEN_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift pipeline tracking each issued beat until its data returns
  always_comb begin
    pvld_d   = pvld_q;
    plast_d  = plast_q;
    pid_d    = pid_q;
    pvld_d[0]  = issue_c;
    plast_d[0] = issue_c && issue_last_c;
    pid_d[0]   = pod_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pvld_d[i]  = pvld_q[i-1];
      plast_d[i] = plast_q[i-1];
      pid_d[i]   = pid_q[i-1];
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      pod_q        <= 2'd0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      pvld_q       <= '0;
      plast_q      <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pid_q[i] <= 2'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pod_q        <= pod_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      pvld_q       <= pvld_d;
      plast_q      <= plast_d;
      pid_q        <= pid_d;
    end
  end

  // Output decode; everything is held quiet while rst is high
  always_comb begin
    rsp_valid = 4'b0000;
    rsp_last  = 4'b0000;
    if (!rst && pvld_q[RD_LAT-1]) begin
      rsp_valid[pid_q[RD_LAT-1]] = 1'b1;
      rsp_last[pid_q[RD_LAT-1]]  = plast_q[RD_LAT-1];
    end
    ddr_raddr_valid = issue_c;
    ddr_raddr       = issue_c ? addr_q : '0;
    rsp_data        = ddr_rdata;
    busy            = !rst && ((state_q == ISSUE) || (|pvld_q));
  end

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Scoreboard bench for ddr_read_arbiter: directed bursts push expected
// grants, addresses and responses; a negedge monitor pops and compares.
module tb_ddr_read_arbiter;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DW     = 512;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned RD_LAT = 12;

  typedef struct {
    logic [1:0] pod;
    logic       last;
  } rsp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [3:0]           req_valid = 4'b0;
  logic [4*ADDR_W-1:0]  req_addr = '0;
  logic [4*LEN_W-1:0]   req_len = '0;
  logic [3:0]           req_ready;
  logic [ADDR_W-1:0]    ddr_raddr;
  logic                 ddr_raddr_valid;
  logic [DW-1:0]        ddr_rdata = '0;
  logic [3:0]           rsp_valid;
  logic [3:0]           rsp_last;
  logic [DW-1:0]        rsp_data;
  logic                 busy;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          abeats = 0;
  logic        auto_drop = 1'b1;
  logic [3:0]  gnt_seen = 4'b0;

  logic [1:0]        gq[$];
  logic [ADDR_W-1:0] aq[$];
  rsp_t              rq[$];
  int                tq[$];
  int                gcyc[$];

  ddr_read_arbiter #(
    .ADDR_W(ADDR_W), .OFFCHIP_DW(DW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready),
    .ddr_raddr(ddr_raddr), .ddr_raddr_valid(ddr_raddr_valid),
    .ddr_rdata(ddr_rdata),
    .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter and a distinct read-data pattern every cycle
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    ddr_rdata = {16{cyc * 32'h9E37_79B9}};
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares every DUT grant, address beat and response
  always @(negedge clk) begin
    logic [1:0]  eg;
    logic [ADDR_W-1:0] ea;
    rsp_t r;
    int t;
    gnt_seen = req_ready;
    if (rst) begin
      chk("rst_outputs", {req_ready, ddr_raddr_valid, ddr_raddr, rsp_valid, rsp_last, busy}, '0);
    end else begin
      if (req_ready != 4'b0) begin
        gcyc.push_back(cyc);
        if (gq.size() == 0) chk("grant_unexpected", req_ready, '0);
        else begin
          eg = gq.pop_front();
          chk("grant", req_ready, 4'b0001 << eg);
        end
        chk("grant_no_issue", ddr_raddr_valid, '0);
      end
      if (ddr_raddr_valid) begin
        tq.push_back(cyc);
        abeats++;
        if (aq.size() == 0) chk("addr_unexpected", ddr_raddr_valid, '0);
        else begin
          ea = aq.pop_front();
          chk("addr", ddr_raddr, ea);
        end
      end else begin
        chk("raddr_idle_zero", ddr_raddr, '0);
      end
      if (rsp_valid != 4'b0) begin
        chk("rsp_onehot", $onehot(rsp_valid), 1);
        if (rq.size() == 0 || tq.size() == 0) chk("rsp_unexpected", rsp_valid, '0);
        else begin
          r = rq.pop_front();
          t = tq.pop_front();
          chk("rsp_valid", rsp_valid, 4'b0001 << r.pod);
          chk("rsp_last", rsp_last, r.last ? (4'b0001 << r.pod) : 4'b0000);
          chk("rsp_latency", cyc - t, RD_LAT);
          chk("rsp_data", rsp_data, ddr_rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~gnt_seen;
  endtask

  task automatic set_req(input int pod, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_addr[pod*ADDR_W +: ADDR_W] = a;
    req_len[pod*LEN_W +: LEN_W]    = l;
    req_valid[pod]                 = 1'b1;
  endtask

  task automatic expect_burst(input logic [1:0] pod, input logic [ADDR_W-1:0] a, input int l);
    gq.push_back(pod);
    for (int i = 0; i <= l; i++) begin
      rsp_t r;
      aq.push_back(ADDR_W'(a + ADDR_W'(i)));
      r.pod  = pod;
      r.last = (i == l);
      rq.push_back(r);
    end
  endtask

  // Wait for all expectations to be consumed, then confirm the block idles
  task automatic drain(input string nm);
    int n = 0;
    while ((gq.size() != 0 || aq.size() != 0 || rq.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout pending g=%0d a=%0d r=%0d", nm, gq.size(), aq.size(), rq.size());
      gq.delete(); aq.delete(); rq.delete(); tq.delete();
    end
    chk({nm, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", req_ready, 4'b0);

    // Single burst: pod 2, 0x0100, 4 beats
    expect_burst(2'd2, 14'h0100, 3);
    set_req(2, 14'h0100, 8'd3);
    tick();
    chk("single_busy", busy, 1'b1);
    drain("single");

    // Reset, then all four pods hold len-0 requests for two rounds
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    gcyc.delete();
    auto_drop = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) expect_burst(2'(p), 14'(16'h0040 + 16'(p)), 0);
    for (int p = 0; p < 4; p++) set_req(p, 14'(16'h0040 + 16'(p)), 8'd0);
    begin
      int n = 0;
      while (gcyc.size() < 8 && n < 200) begin
        tick();
        n++;
      end
    end
    req_valid = 4'b0;
    auto_drop = 1'b1;
    drain("rr");
    chk("rr_grant_count", gcyc.size(), 8);
    for (int i = 1; i < 8 && i < gcyc.size(); i++)
      chk("rr_bubble_spacing", gcyc[i] - gcyc[i-1], 2);

    // Address wrap
    expect_burst(2'd0, 14'h3FFE, 3);
    set_req(0, 14'h3FFE, 8'd3);
    drain("wrap");

    // Overlapping bursts from pods 1 and 3
    expect_burst(2'd1, 14'h0200, 1);
    expect_burst(2'd3, 14'h0300, 1);
    set_req(1, 14'h0200, 8'd1);
    set_req(3, 14'h0300, 8'd1);
    drain("overlap");

    // Reset at the second beat of an 8-beat burst
    abeats = 0;
    gq.push_back(2'd2);
    aq.push_back(14'h0500);
    aq.push_back(14'h0501);
    set_req(2, 14'h0500, 8'd7);
    begin
      int n = 0;
      while (abeats < 2 && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("abort_reached_beat2", abeats, 2);
    end
    rst = 1'b1;
    tq.delete();
    req_valid = 4'b0;
    set_req(0, 14'h0055, 8'd0);
    repeat (2) tick();
    rst = 1'b0;
    expect_burst(2'd0, 14'h0055, 0);
    drain("abort");

    // Maximum burst length
    expect_burst(2'd1, 14'h1000, 255);
    set_req(1, 14'h1000, 8'd255);
    drain("maxlen");

    repeat (RD_LAT + 4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
